cis_cds_accumulator: RTL and testbench

//  Receive side of the CIS control waveforms. Consumes the baseline/signal sample strobes
//  and the integration level driven to the sensor, and pairs them with ADC conversions.

---
 rtl/cis_cds_accumulator.sv | 180 ++++++++++++++++++
 tb/tb_cis_cds_accumulator.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cis_cds_accumulator.sv
// Skipper CDS accumulator: pairs baseline/signal strobes with ADC samples and sums (base - sig) per pixel.
// Build option: define CDS_SATURATE_EN to clamp the accumulator instead of letting it wrap.
module cis_cds_accumulator #(
    parameter int ADC_WIDTH = 16,
    parameter int SKIP_W    = 10,
    parameter int ACC_WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 integration,
    input  logic                 smp_base,
    input  logic                 smp_sig,
    input  logic [SKIP_W-1:0]    skip_samples,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [ACC_WIDTH-1:0] pix_data,
    output logic [SKIP_W:0]      pix_nsamp,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 seq_err,
    output logic                 overrun
);

    typedef enum logic [1:0] {IDLE, WAIT_BASE, WAIT_SIG, OUTPUT} state_t;

    state_t                 state_reg, state_next;
    logic                   int_prev_reg, base_prev_reg, sig_prev_reg;
    logic                   base_armed_reg, base_armed_next;
    logic                   sig_armed_reg, sig_armed_next;
    logic [ADC_WIDTH-1:0]   base_reg, base_next;
    logic [SKIP_W:0]        n_tgt_reg, n_tgt_next;
    logic [SKIP_W:0]        cnt_reg, cnt_next;
    logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
    logic [ACC_WIDTH-1:0]   pix_data_reg, pix_data_next;
    logic [SKIP_W:0]        pix_nsamp_reg, pix_nsamp_next;
    logic                   pix_valid_reg, pix_valid_next;
    logic                   seq_err_reg, seq_err_next;
    logic                   overrun_reg, overrun_next;

    logic int_rise, int_fall, base_rise, sig_rise;
    logic base_arm_eff, sig_arm_eff;
    logic [ADC_WIDTH:0]     diff;
    logic [ACC_WIDTH-1:0]   diff_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [SKIP_W:0]        cnt_inc;

    assign int_rise  = integration & ~int_prev_reg;
    assign int_fall  = ~integration & int_prev_reg;
    assign base_rise = smp_base & ~base_prev_reg;
    assign sig_rise  = smp_sig & ~sig_prev_reg;

    // A capture may happen on the strobe's own rise cycle; an integration rise cancels any arming.
    assign base_arm_eff = ~int_rise & (base_armed_reg | base_rise);
    assign sig_arm_eff  = ~int_rise & (sig_armed_reg | sig_rise);

    assign diff     = {1'b0, base_reg} - {1'b0, adc_data};
    assign diff_ext = {{(ACC_WIDTH-ADC_WIDTH-1){diff[ADC_WIDTH]}}, diff};
    assign cnt_inc  = cnt_reg + {{SKIP_W{1'b0}}, 1'b1};

`ifdef CDS_SATURATE_EN
    logic [ACC_WIDTH:0] sum_full;
    assign sum_full = {acc_reg[ACC_WIDTH-1], acc_reg} + {diff_ext[ACC_WIDTH-1], diff_ext};
    always_comb begin
        acc_sum = sum_full[ACC_WIDTH-1:0];
        if (sum_full[ACC_WIDTH] != sum_full[ACC_WIDTH-1]) begin
            acc_sum = sum_full[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign acc_sum = acc_reg + diff_ext;
`endif

    always_comb begin
        state_next      = state_reg;
        base_armed_next = 1'b0;
        sig_armed_next  = 1'b0;
        base_next       = base_reg;
        n_tgt_next      = n_tgt_reg;
        cnt_next        = cnt_reg;
        acc_next        = acc_reg;
        pix_data_next   = pix_data_reg;
        pix_nsamp_next  = pix_nsamp_reg;
        pix_valid_next  = pix_valid_reg;
        seq_err_next    = seq_err_reg;
        overrun_next    = overrun_reg;

        if (int_fall) begin
            // A fresh readout always wins; any unfinished or unconsumed pixel is discarded.
            if (state_reg != IDLE) overrun_next = 1'b1;
            state_next     = WAIT_BASE;
            n_tgt_next     = {1'b0, skip_samples} + {{SKIP_W{1'b0}}, 1'b1};
            cnt_next       = '0;
            acc_next       = '0;
            pix_valid_next = 1'b0;
        end else begin
            case (state_reg)
                WAIT_BASE: begin
                    if (sig_rise) seq_err_next = 1'b1;
                    if (adc_valid && base_arm_eff) begin
                        base_next  = adc_data;
                        state_next = WAIT_SIG;
                    end else begin
                        base_armed_next = base_arm_eff;
                    end
                end
                WAIT_SIG: begin
                    if (adc_valid && base_arm_eff) begin
                        base_next      = adc_data;
                        sig_armed_next = sig_arm_eff;
                    end else if (adc_valid && sig_arm_eff) begin
                        acc_next = acc_sum;
                        cnt_next = cnt_inc;
                        if (cnt_inc == n_tgt_reg) begin
                            state_next     = OUTPUT;
                            pix_data_next  = acc_sum;
                            pix_nsamp_next = cnt_inc;
                            pix_valid_next = 1'b1;
                        end else begin
                            state_next = WAIT_BASE;
                        end
                    end else begin
                        base_armed_next = base_arm_eff;
                        sig_armed_next  = sig_arm_eff;
                    end
                end
                OUTPUT: begin
                    if (pix_valid_reg && pix_ready) begin
                        pix_valid_next = 1'b0;
                        state_next     = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            int_prev_reg   <= 1'b0;
            base_prev_reg  <= 1'b0;
            sig_prev_reg   <= 1'b0;
            base_armed_reg <= 1'b0;
            sig_armed_reg  <= 1'b0;
            base_reg       <= '0;
            n_tgt_reg      <= '0;
            cnt_reg        <= '0;
            acc_reg        <= '0;
            pix_data_reg   <= '0;
            pix_nsamp_reg  <= '0;
            pix_valid_reg  <= 1'b0;
            seq_err_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            int_prev_reg   <= integration;
            base_prev_reg  <= smp_base;
            sig_prev_reg   <= smp_sig;
            base_armed_reg <= base_armed_next;
            sig_armed_reg  <= sig_armed_next;
            base_reg       <= base_next;
            n_tgt_reg      <= n_tgt_next;
            cnt_reg        <= cnt_next;
            acc_reg        <= acc_next;
            pix_data_reg   <= pix_data_next;
            pix_nsamp_reg  <= pix_nsamp_next;
            pix_valid_reg  <= pix_valid_next;
            seq_err_reg    <= seq_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign pix_data  = pix_data_reg;
    assign pix_nsamp = pix_nsamp_reg;
    assign pix_valid = pix_valid_reg;
    assign seq_err   = seq_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_cis_cds_accumulator.sv
// Directed bench for cis_cds_accumulator: a default-width instance plus a narrow (ACC_WIDTH=18) one for overflow.
module tb_cis_cds_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        integration, smp_base, smp_sig, adc_valid, pix_ready;
    logic [9:0]  skip_samples;
    logic [2:0]  skip_small;
    logic [15:0] adc_data;

    logic [27:0] pix_data;
    logic [10:0] pix_nsamp;
    logic        pix_valid, seq_err, overrun;

    logic [17:0] n_pix_data;
    logic [3:0]  n_pix_nsamp;
    logic        n_pix_valid, n_seq_err, n_overrun;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cis_cds_accumulator #(.ADC_WIDTH(16), .SKIP_W(10), .ACC_WIDTH(28)) dut (
        .clk(clk), .reset_n(reset_n), .integration(integration), .smp_base(smp_base),
        .smp_sig(smp_sig), .skip_samples(skip_samples), .adc_data(adc_data), .adc_valid(adc_valid),
        .pix_data(pix_data), .pix_nsamp(pix_nsamp), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .seq_err(seq_err), .overrun(overrun)
    );

    cis_cds_accumulator #(.ADC_WIDTH(16), .SKIP_W(3), .ACC_WIDTH(18)) dut_narrow (
        .clk(clk), .reset_n(reset_n), .integration(integration), .smp_base(smp_base),
        .smp_sig(smp_sig), .skip_samples(skip_small), .adc_data(adc_data), .adc_valid(adc_valid),
        .pix_data(n_pix_data), .pix_nsamp(n_pix_nsamp), .pix_valid(n_pix_valid), .pix_ready(pix_ready),
        .seq_err(n_seq_err), .overrun(n_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_readout();
        @(negedge clk); integration = 1'b1;
        @(negedge clk); integration = 1'b0;
        @(negedge clk);
    endtask

    // One baseline/signal pair, with an unarmed ADC sample first and a multi-cycle baseline strobe.
    task automatic do_pair(input logic [15:0] b, input logic [15:0] s, input bit last);
        @(negedge clk); adc_valid = 1'b1; adc_data = 16'd12345;
        @(negedge clk); smp_base = 1'b1; adc_data = b;
        @(negedge clk); adc_valid = 1'b0;
        @(negedge clk); smp_base = 1'b0;
        @(negedge clk); smp_sig = 1'b1;
        @(negedge clk); adc_valid = 1'b1; adc_data = s;
        if (last) check("valid_before_capture", 32'(pix_valid), 32'd0);
        @(negedge clk); adc_valid = 1'b0; smp_sig = 1'b0;
        if (last) check("valid_one_clk_after", 32'(pix_valid), 32'd1);
    endtask

    task automatic accept();
        @(negedge clk); pix_ready = 1'b1;
        @(negedge clk); pix_ready = 1'b0;
        check("valid_drop_after_accept", 32'(pix_valid), 32'd0);
    endtask

    initial begin
        logic [27:0] neg30;
        logic [27:0] d0;
        logic [10:0] n0;
        bit          stable;
        neg30 = -28'sd30;

        reset_n = 1'b0; integration = 1'b0; smp_base = 1'b0; smp_sig = 1'b0;
        adc_valid = 1'b0; adc_data = '0; pix_ready = 1'b0;
        skip_samples = '0; skip_small = 3'd7;
        repeat (3) @(negedge clk);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_pix_nsamp", 32'(pix_nsamp), 32'd0);
        check("rst_flags", {30'd0, seq_err, overrun}, 32'd0);
        reset_n = 1'b1;

        // Single pair
        skip_samples = 10'd0;
        start_readout();
        do_pair(16'd1000, 16'd400, 1'b1);
        check("p1_data", 32'(pix_data), 32'd600);
        check("p1_nsamp", 32'(pix_nsamp), 32'd1);
        accept();

        // Four pairs, then backpressure
        skip_samples = 10'd3;
        start_readout();
        do_pair(16'd1000, 16'd400, 1'b0);
        do_pair(16'd1000, 16'd500, 1'b0);
        do_pair(16'd900, 16'd900, 1'b0);
        do_pair(16'd800, 16'd1000, 1'b1);
        check("p4_data", 32'(pix_data), 32'd900);
        check("p4_nsamp", 32'(pix_nsamp), 32'd4);
        d0 = pix_data; n0 = pix_nsamp; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_data !== d0 || pix_nsamp !== n0 || pix_valid !== 1'b1) stable = 1'b0;
        end
        check("hold_stable_20clk", 32'(stable), 32'd1);
        accept();
        check("no_err_yet", {30'd0, seq_err, overrun}, 32'd0);

        // Signal strobe with no baseline
        skip_samples = 10'd1;
        start_readout();
        @(negedge clk); smp_sig = 1'b1;
        @(negedge clk); adc_valid = 1'b1; adc_data = 16'd9999;
        @(negedge clk); adc_valid = 1'b0; smp_sig = 1'b0;
        check("seq_err_set", 32'(seq_err), 32'd1);
        do_pair(16'd700, 16'd200, 1'b0);
        do_pair(16'd300, 16'd100, 1'b1);
        check("seq_data", 32'(pix_data), 32'd700);
        check("seq_nsamp", 32'(pix_nsamp), 32'd2);

        // New readout while the result is still pending
        check("pending_valid", 32'(pix_valid), 32'd1);
        skip_samples = 10'd0;
        start_readout();
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_drops_valid", 32'(pix_valid), 32'd0);
        do_pair(16'd50, 16'd80, 1'b1);
        check("ovr_data_neg", 32'(pix_data), 32'(neg30));
        check("ovr_nsamp", 32'(pix_nsamp), 32'd1);
        accept();

        // Asynchronous reset while waiting for the signal sample
        start_readout();
        @(negedge clk); smp_base = 1'b1; adc_valid = 1'b1; adc_data = 16'd500;
        @(negedge clk); smp_base = 1'b0; adc_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst_flags", {30'd0, seq_err, overrun}, 32'd0);
        check("arst_pix_data", 32'(pix_data), 32'd0);
        check("arst_pix_nsamp", 32'(pix_nsamp), 32'd0);
        check("arst_pix_valid", 32'(pix_valid), 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // Clean readout after reset; the narrow instance overflows
        skip_samples = 10'd7;
        start_readout();
        for (int i = 0; i < 8; i++) do_pair(16'd65535, 16'd0, i == 7);
        check("big_data", 32'(pix_data), 32'd524280);
        check("big_nsamp", 32'(pix_nsamp), 32'd8);
        check("big_flags", {30'd0, seq_err, overrun}, 32'd0);
        check("narrow_valid", 32'(n_pix_valid), 32'd1);
        check("narrow_nsamp", 32'(n_pix_nsamp), 32'd8);
`ifdef CDS_SATURATE_EN
        check("narrow_data_sat", 32'(n_pix_data), 32'd131071);
`else
        check("narrow_data_wrap", 32'(n_pix_data), 32'd262136);
`endif
        accept();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
